// File: rtl/axi_stream_checker.sv
// axi_stream_checker: AXI4-Stream sink that checks an incrementing-word packet
// pattern and the TLAST position. It counts beats and errors and records the
// TDEST/TID of the last packet. Software arms, monitors and clears it over an
// AXI4-Lite slave port.
module axi_stream_checker #(
  parameter int unsigned STREAM_DATA_WIDTH  = 32,
  parameter int unsigned STREAM_ID_WIDTH    = 2,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            clock,
  input  logic                            reset,
  // AXI4-Stream sink
  input  logic [STREAM_DATA_WIDTH-1:0]    TDATA,
  input  logic                            TLAST,
  input  logic [STREAM_ID_WIDTH-1:0]      TID,
  input  logic [1:0]                      TDEST,
  input  logic                            TVALID,
  output logic                            TREADY,
  // AXI4-Lite slave
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned SW = STREAM_DATA_WIDTH;

  localparam logic [AW-1:0] ADDR_CONTROL = AW'(32'h00);
  localparam logic [AW-1:0] ADDR_STATUS  = AW'(32'h04);
  localparam logic [AW-1:0] ADDR_BEATS   = AW'(32'h08);
  localparam logic [AW-1:0] ADDR_ERRORS  = AW'(32'h0C);
  localparam logic [AW-1:0] ADDR_EXPECT  = AW'(32'h10);
  localparam logic [AW-1:0] ADDR_LASTID  = AW'(32'h14);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // AXI4-Lite channel state
  logic          wpend_q, wpend_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic          bvalid_q, bvalid_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] rd_mux;

  // Software-visible registers
  logic          arm_q, arm_d;
  logic          throttle_q, throttle_d;
  logic [DW-1:0] exp_beats_q, exp_beats_d;
  logic [DW-1:0] beat_cnt_q, beat_cnt_d;
  logic [DW-1:0] err_cnt_q, err_cnt_d;
  logic          error_q, error_d;
  logic [1:0]    last_dest_q, last_dest_d;
  logic [STREAM_ID_WIDTH-1:0] last_id_q, last_id_d;

  // Stream checking state
  logic [SW-1:0] exp_word_q, exp_word_d;
  logic          toggle_q;

  logic          aw_hs, w_hs, ar_hs;
  logic [AW-1:0] wr_addr;
  logic          tready;
  logic          beat_acc;
  logic          data_err, len_err, beat_err;
  logic          unused_inputs;

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], awaddr_q[1:0]};

  assign aw_hs   = S_AXI_AWVALID && !wpend_q;
  assign w_hs    = S_AXI_WVALID && wpend_q;
  assign ar_hs   = S_AXI_ARVALID && !rvalid_q;
  assign wr_addr = {awaddr_q[AW-1:2], 2'b00};

  assign S_AXI_AWREADY = !wpend_q;
  assign S_AXI_WREADY  = wpend_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = !rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

  // TREADY is built only from registered state, so it never follows TVALID;
  // a pending arm pulse blocks acceptance so no beat is lost to the restart.
  assign tready   = (state_q == S_RECV) && !arm_q && (!throttle_q || toggle_q);
  assign TREADY   = tready;
  assign beat_acc = TVALID && tready;

  assign data_err = (TDATA != exp_word_q);
  assign len_err  = (exp_beats_q != '0) &&
                    (TLAST != (beat_cnt_q == (exp_beats_q - DW'(1))));

  // AXI4-Lite handshakes: address latch, write response and read data capture
  always_comb begin
    wpend_d  = wpend_q;
    awaddr_d = awaddr_q;
    bvalid_d = bvalid_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (aw_hs) begin
      wpend_d  = 1'b1;
      awaddr_d = S_AXI_AWADDR;
    end else if (w_hs) begin
      wpend_d = 1'b0;
    end
    if (w_hs) begin
      bvalid_d = 1'b1;
    end else if (S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // Register read decode; unmapped offsets read as zero
  always_comb begin
    rd_mux = '0;
    case ({S_AXI_ARADDR[AW-1:2], 2'b00})
      ADDR_CONTROL: rd_mux[1] = throttle_q;
      ADDR_STATUS: begin
        rd_mux[0] = (state_q == S_RECV);
        rd_mux[1] = (state_q == S_DONE);
        rd_mux[2] = error_q;
      end
      ADDR_BEATS:  rd_mux = beat_cnt_q;
      ADDR_ERRORS: rd_mux = err_cnt_q;
      ADDR_EXPECT: rd_mux = exp_beats_q;
      ADDR_LASTID: begin
        rd_mux[1:0]                 = last_dest_q;
        rd_mux[8 +: STREAM_ID_WIDTH] = last_id_q;
      end
      default: rd_mux = '0;
    endcase
  end

  // Register writes; writes to read-only or unmapped offsets are dropped
  always_comb begin
    throttle_d  = throttle_q;
    exp_beats_d = exp_beats_q;
    arm_d       = 1'b0;
    if (w_hs) begin
      case (wr_addr)
        ADDR_CONTROL: begin
          arm_d = S_AXI_WDATA[0];
          if (S_AXI_WSTRB[0]) throttle_d = S_AXI_WDATA[1];
        end
        ADDR_EXPECT: begin
          for (int unsigned b = 0; b < DW / 8; b++) begin
            if (S_AXI_WSTRB[b]) exp_beats_d[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
          end
        end
        default: ;
      endcase
    end
  end

  // Receive FSM next state; an arm pulse restarts reception from any state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: ;
      S_RECV: if (beat_acc && TLAST) state_d = S_DONE;
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
    if (arm_q) state_d = S_RECV;
  end

  // Per-beat checking: counters, expected word, sticky error and last IDs
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    err_cnt_d   = err_cnt_q;
    exp_word_d  = exp_word_q;
    error_d     = error_q;
    last_dest_d = last_dest_q;
    last_id_d   = last_id_q;
    beat_err    = 1'b0;
    if (arm_q) begin
      beat_cnt_d = '0;
      err_cnt_d  = '0;
      exp_word_d = '0;
      error_d    = 1'b0;
    end else if (beat_acc) begin
      if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + DW'(1);
      exp_word_d = exp_word_q + SW'(1);
      // Data and length failures on the same beat count as a single error
      beat_err = data_err || len_err;
      if (beat_err) begin
        error_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + DW'(1);
      end
      if (TLAST) begin
        last_dest_d = TDEST;
        last_id_d   = TID;
      end
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wpend_q     <= 1'b0;
      awaddr_q    <= '0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      arm_q       <= 1'b0;
      throttle_q  <= 1'b0;
      exp_beats_q <= '0;
      beat_cnt_q  <= '0;
      err_cnt_q   <= '0;
      error_q     <= 1'b0;
      last_dest_q <= '0;
      last_id_q   <= '0;
      exp_word_q  <= '0;
      toggle_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wpend_q     <= wpend_d;
      awaddr_q    <= awaddr_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      arm_q       <= arm_d;
      throttle_q  <= throttle_d;
      exp_beats_q <= exp_beats_d;
      beat_cnt_q  <= beat_cnt_d;
      err_cnt_q   <= err_cnt_d;
      error_q     <= error_d;
      last_dest_q <= last_dest_d;
      last_id_q   <= last_id_d;
      exp_word_q  <= exp_word_d;
      toggle_q    <= ~toggle_q;
    end
  end

endmodule

// File: tb/tb_axi_stream_checker.sv
// Bench for axi_stream_checker: a packet table drives the main checks. Register
// read expectations are queued when each read is issued and compared when RDATA
// is returned.
module tb_axi_stream_checker;
  localparam int unsigned SDW = 32;
  localparam int unsigned IDW = 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;

  localparam logic [AW-1:0] A_CTRL = 5'h00;
  localparam logic [AW-1:0] A_STAT = 5'h04;
  localparam logic [AW-1:0] A_BEAT = 5'h08;
  localparam logic [AW-1:0] A_ERR  = 5'h0C;
  localparam logic [AW-1:0] A_EXPB = 5'h10;
  localparam logic [AW-1:0] A_LID  = 5'h14;
  localparam logic [AW-1:0] A_UNM  = 5'h18;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [SDW-1:0] TDATA = '0;
  logic           TLAST = 1'b0;
  logic [IDW-1:0] TID = '0;
  logic [1:0]     TDEST = '0;
  logic           TVALID = 1'b0;
  logic           TREADY;

  logic [AW-1:0]   S_AXI_AWADDR = '0;
  logic [2:0]      S_AXI_AWPROT = '0;
  logic            S_AXI_AWVALID = 1'b0;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA = '0;
  logic [DW/8-1:0] S_AXI_WSTRB = '1;
  logic            S_AXI_WVALID = 1'b0;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY = 1'b1;
  logic [AW-1:0]   S_AXI_ARADDR = '0;
  logic [2:0]      S_AXI_ARPROT = '0;
  logic            S_AXI_ARVALID = 1'b0;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY = 1'b1;

  always #5 clock = ~clock;

  axi_stream_checker #(
    .STREAM_DATA_WIDTH (SDW),
    .STREAM_ID_WIDTH   (IDW),
    .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_ADDR_WIDTH(AW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .TDATA        (TDATA),
    .TLAST        (TLAST),
    .TID          (TID),
    .TDEST        (TDEST),
    .TVALID       (TVALID),
    .TREADY       (TREADY),
    .S_AXI_AWADDR (S_AXI_AWADDR),
    .S_AXI_AWPROT (S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA  (S_AXI_WDATA),
    .S_AXI_WSTRB  (S_AXI_WSTRB),
    .S_AXI_WVALID (S_AXI_WVALID),
    .S_AXI_WREADY (S_AXI_WREADY),
    .S_AXI_BRESP  (S_AXI_BRESP),
    .S_AXI_BVALID (S_AXI_BVALID),
    .S_AXI_BREADY (S_AXI_BREADY),
    .S_AXI_ARADDR (S_AXI_ARADDR),
    .S_AXI_ARPROT (S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA  (S_AXI_RDATA),
    .S_AXI_RRESP  (S_AXI_RRESP),
    .S_AXI_RVALID (S_AXI_RVALID),
    .S_AXI_RREADY (S_AXI_RREADY)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic tready_after_w  = 1'b0;
  logic rvalid_after_ar = 1'b0;
  logic [1:0] bresp_seen = 2'b11;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   exp;
  } rd_exp_t;
  rd_exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // Read-data scoreboard: the beat is taken at the next rising edge
  always @(negedge clock) begin
    rd_exp_t e;
    if (S_AXI_RVALID && S_AXI_RREADY) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_unexpected: got 0x%0h with no read pending", S_AXI_RDATA);
      end else begin
        e = sb.pop_front();
        check($sformatf("rd@0x%02h", e.addr), S_AXI_RDATA, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, output logic bv);
    logic tr;
    int n;
    bv = 1'b0;
    S_AXI_AWADDR = a;
    S_AXI_AWVALID = 1'b1;
    n = 0;
    do begin tr = S_AXI_AWREADY; tick(); n++; end while (!tr && n < 20);
    S_AXI_AWVALID = 1'b0;
    if (!tr) begin timeout("aw_handshake"); return; end
    S_AXI_WDATA = d;
    S_AXI_WVALID = 1'b1;
    n = 0;
    do begin tr = S_AXI_WREADY; tick(); n++; end while (!tr && n < 20);
    S_AXI_WVALID = 1'b0;
    if (!tr) begin timeout("w_handshake"); return; end
    tready_after_w = TREADY;
    n = 0;
    do begin tr = S_AXI_BVALID; bresp_seen = S_AXI_BRESP; tick(); n++; end while (!tr && n < 20);
    bv = tr;
    if (!tr) timeout("b_response");
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    logic unused_bv;
    axi_write(a, d, unused_bv);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input logic [31:0] exp);
    logic tr;
    int n;
    sb.push_back('{addr: a, exp: exp});
    S_AXI_ARADDR = a;
    S_AXI_ARVALID = 1'b1;
    n = 0;
    do begin tr = S_AXI_ARREADY; tick(); n++; end while (!tr && n < 20);
    S_AXI_ARVALID = 1'b0;
    if (!tr) begin timeout("ar_handshake"); sb.delete(); return; end
    rvalid_after_ar = S_AXI_RVALID;
    n = 0;
    while (sb.size() != 0 && n < 20) begin tick(); n++; end
    if (sb.size() != 0) begin timeout("rd_response"); sb.delete(); end
  endtask

  task automatic send_pkt(input int nbeats, input int tlast_at, input int bad,
                          input logic [1:0] dest, input logic [IDW-1:0] id, output int cycles);
    logic tr;
    int n;
    cycles = 0;
    TDEST = dest;
    TID = id;
    for (int i = 0; i < nbeats; i++) begin
      TDATA = (i == bad) ? 32'hDEAD : SDW'(i);
      TLAST = (i == tlast_at);
      TVALID = 1'b1;
      n = 0;
      do begin tr = TREADY; tick(); n++; cycles++; end while (!tr && n < 100);
      if (!tr) begin TVALID = 1'b0; TLAST = 1'b0; timeout("beat_accept"); return; end
    end
    TVALID = 1'b0;
    TLAST = 1'b0;
  endtask

  typedef struct {
    int          exp_beats;
    int          nbeats;
    int          tlast_at;
    int          bad;
    logic        thr;
    logic [1:0]  dest;
    logic [IDW-1:0] id;
    logic [31:0] st;
    logic [31:0] bc;
    logic [31:0] ec;
  } pkt_vec_t;

  pkt_vec_t vec[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic tr;
    logic bv;
    int n;
    int cyc;
    int hi;
    logic [31:0] lid;

    //         EXPB n  TL  bad thr dest id    STATUS BEATS ERRS
    vec[0] = '{16, 16, 15, -1, 1'b0, 2'd1, 2'd2, 32'h2, 32'd16, 32'd0};
    vec[1] = '{16, 16, 15,  5, 1'b0, 2'd2, 2'd1, 32'h6, 32'd16, 32'd1};
    vec[2] = '{ 8,  6,  5, -1, 1'b0, 2'd3, 2'd3, 32'h6, 32'd6,  32'd1};
    vec[3] = '{16, 16, 15, -1, 1'b1, 2'd0, 2'd1, 32'h2, 32'd16, 32'd0};
    vec[4] = '{ 4,  6,  5, -1, 1'b0, 2'd1, 2'd0, 32'h6, 32'd6,  32'd2};
    vec[5] = '{ 4,  3,  2,  2, 1'b0, 2'd2, 2'd3, 32'h6, 32'd3,  32'd1};
    vec[6] = '{ 0,  3,  2, -1, 1'b0, 2'd3, 2'd0, 32'h2, 32'd3,  32'd0};

    // Reset state
    repeat (3) tick();
    check("rst_tready", TREADY, 0);
    check("rst_awready", S_AXI_AWREADY, 1);
    check("rst_wready", S_AXI_WREADY, 0);
    check("rst_bvalid", S_AXI_BVALID, 0);
    check("rst_arready", S_AXI_ARREADY, 1);
    check("rst_rvalid", S_AXI_RVALID, 0);
    check("rst_rdata", S_AXI_RDATA, 0);
    reset = 1'b0;
    tick();
    axi_read(A_CTRL, 0);
    axi_read(A_STAT, 0);
    axi_read(A_BEAT, 0);
    axi_read(A_ERR, 0);
    axi_read(A_EXPB, 0);
    axi_read(A_LID, 0);

    // Packet table
    for (int r = 0; r < 7; r++) begin
      wr(A_CTRL, {30'b0, vec[r].thr, 1'b0});
      wr(A_EXPB, 32'(vec[r].exp_beats));
      wr(A_CTRL, {30'b0, vec[r].thr, 1'b1});
      send_pkt(vec[r].nbeats, vec[r].tlast_at, vec[r].bad, vec[r].dest, vec[r].id, cyc);
      if (vec[r].thr)
        check($sformatf("v%0d_throttle_cycles_31_32", r), 32'(cyc >= 31 && cyc <= 32), 1);
      else
        check($sformatf("v%0d_cycles", r), 32'(cyc), 32'(vec[r].nbeats));
      lid = 32'(vec[r].dest) | (32'(vec[r].id) << 8);
      axi_read(A_STAT, vec[r].st);
      axi_read(A_BEAT, vec[r].bc);
      axi_read(A_ERR, vec[r].ec);
      axi_read(A_LID, lid);
      axi_read(A_CTRL, {30'b0, vec[r].thr, 1'b0});
    end

    // DONE holds: beats stall and are not counted
    TDATA = 32'd3;
    TVALID = 1'b1;
    hi = 0;
    repeat (5) begin hi += int'(TREADY); tick(); end
    TVALID = 1'b0;
    check("done_tready_low", 32'(hi), 0);
    axi_read(A_BEAT, 3);

    // Re-arm while receiving: TREADY drops for the arm cycle, counters restart
    wr(A_EXPB, 0);
    wr(A_CTRL, 1);
    send_pkt(3, -1, -1, 2'd0, 2'd0, cyc);
    axi_read(A_STAT, 1);
    axi_read(A_BEAT, 3);
    wr(A_CTRL, 1);
    check("arm_cycle_tready", tready_after_w, 0);
    check("tready_after_arm", TREADY, 1);
    send_pkt(4, 3, -1, 2'd2, 2'd1, cyc);
    axi_read(A_STAT, 2);
    axi_read(A_BEAT, 4);
    axi_read(A_ERR, 0);
    axi_read(A_LID, 32'h102);

    // Reset mid-packet, then a clean resend
    wr(A_EXPB, 16);
    wr(A_CTRL, 1);
    send_pkt(7, -1, -1, 2'd1, 2'd1, cyc);
    TDATA = 32'd7;
    TVALID = 1'b1;
    reset = 1'b1;
    tick();
    check("reset_tready", TREADY, 0);
    TVALID = 1'b0;
    reset = 1'b0;
    tick();
    check("reset_awready", S_AXI_AWREADY, 1);
    check("reset_arready", S_AXI_ARREADY, 1);
    check("reset_rdata", S_AXI_RDATA, 0);
    axi_read(A_STAT, 0);
    axi_read(A_BEAT, 0);
    axi_read(A_EXPB, 0);
    axi_read(A_LID, 0);
    wr(A_EXPB, 16);
    wr(A_CTRL, 1);
    send_pkt(16, 15, -1, 2'd1, 2'd1, cyc);
    axi_read(A_STAT, 2);
    axi_read(A_BEAT, 16);
    axi_read(A_ERR, 0);

    // Unmapped read and write to a read-only register
    axi_read(A_UNM, 0);
    check("ar_latency_rvalid", rvalid_after_ar, 1);
    axi_write(A_BEAT, 32'h1234, bv);
    check("ro_write_bvalid", bv, 1);
    check("ro_write_bresp", bresp_seen, 0);
    axi_read(A_BEAT, 16);

    // RVALID held while RREADY is low
    S_AXI_RREADY = 1'b0;
    sb.push_back('{addr: A_EXPB, exp: 32'd16});
    S_AXI_ARADDR = A_EXPB;
    S_AXI_ARVALID = 1'b1;
    n = 0;
    do begin tr = S_AXI_ARREADY; tick(); n++; end while (!tr && n < 20);
    S_AXI_ARVALID = 1'b0;
    repeat (3) tick();
    check("rvalid_hold", S_AXI_RVALID, 1);
    check("arready_while_rvalid", S_AXI_ARREADY, 0);
    check("rresp", S_AXI_RRESP, 0);
    S_AXI_RREADY = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 20) begin tick(); n++; end
    if (sb.size() != 0) begin timeout("rd_hold_response"); sb.delete(); end
    check("rvalid_drop", S_AXI_RVALID, 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
